// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset PC,
// fetch FSM states and instruction field positions.
package instr_fetch_unit_pkg;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;

  localparam int unsigned OPC_LSB   = 26;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_LSB = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD,
    ST_HALTED
  } fetch_state_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: the fetch unit is master, the memory is slave.
interface instr_fetch_unit_if
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;

  modport master (output imem_en, output imem_addr, input imem_rdata);
  modport slave  (input imem_en, input imem_addr, output imem_rdata);
endinterface

// File: rtl/instr_fetch_unit_next_pc_logic.sv
// Next-PC selection: return > jump > taken branch > sequential.
module next_pc_logic #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       imm_sext,
  input  logic [25:0]       target,
  input  logic [ADDR_W-1:0] ret_addr,
  input  logic              branch,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic              ret_pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] jmp_tgt;
  logic [ADDR_W-1:0] ret_tgt;

  always_comb begin
    pc_plus4 = pc + ADDR_W'(4);
    br_tgt   = pc_plus4 + (ADDR_W'(imm_sext) << 2);
    jmp_tgt  = {pc_plus4[ADDR_W-1:28], target, 2'b00};
    ret_tgt  = ret_addr & ~ADDR_W'(3);
    if (ret_pc)                      next_pc = ret_tgt;
    else if (jump)                   next_pc = jmp_tgt;
    else if (branch && branch_taken) next_pc = br_tgt;
    else                             next_pc = pc_plus4;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle-processor front end: PC and IR registers, instruction-memory
// fetch FSM with configurable latency, and IR field decode.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       IMEM_LAT = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_req,
  input  logic                pc_update,
  input  logic                branch,
  input  logic                branch_taken,
  input  logic                jump,
  input  logic                ret_pc,
  input  logic [ADDR_W-1:0]   ret_addr,
  input  logic                halt,
  instr_fetch_unit_if.master  imem,
  output logic [ADDR_W-1:0]   pc,
  output logic [ADDR_W-1:0]   pc_plus4,
  output logic                instr_valid,
  output logic                busy,
  output logic                halted,
  output logic [5:0]          opcode,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [4:0]          rd,
  output logic [4:0]          shamt,
  output logic [5:0]          funct,
  output logic [31:0]         imm_sext,
  output logic [25:0]         target
);

  localparam int unsigned CNT_W = (IMEM_LAT > 1) ? $clog2(IMEM_LAT) : 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  lat_q, lat_d;
  logic [ADDR_W-1:0] next_pc;

  next_pc_logic #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc           (pc_q),
    .imm_sext     (imm_sext),
    .target       (target),
    .ret_addr     (ret_addr),
    .branch       (branch),
    .branch_taken (branch_taken),
    .jump         (jump),
    .ret_pc       (ret_pc),
    .pc_plus4     (pc_plus4),
    .next_pc      (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    lat_d   = lat_q;
    if (halt) begin
      state_d = ST_HALTED;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (fetch_req) begin
            state_d = ST_ISSUE;
            valid_d = 1'b0;
          end
        end
        ST_ISSUE: begin
          state_d = ST_WAIT;
          lat_d   = CNT_W'(IMEM_LAT - 1);
        end
        ST_WAIT: begin
          if (lat_q == '0) begin
            ir_d    = imem.imem_rdata;
            valid_d = 1'b1;
            state_d = ST_HOLD;
          end else begin
            lat_d = lat_q - 1'b1;
          end
        end
        ST_HALTED: ;
        default: state_d = ST_IDLE;
      endcase
      // A PC change invalidates the IR even if an old-address fetch lands this cycle.
      if (pc_update && state_q != ST_HALTED) begin
        pc_d    = next_pc;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      valid_q <= 1'b0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    imem.imem_en   = (state_q == ST_ISSUE);
    imem.imem_addr = pc_q;
    pc             = pc_q;
    instr_valid    = valid_q;
    busy           = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    halted         = (state_q == ST_HALTED);
    opcode         = ir_q[OPC_LSB +: 6];
    rs             = ir_q[RS_LSB +: 5];
    rt             = ir_q[RT_LSB +: 5];
    rd             = ir_q[RD_LSB +: 5];
    shamt          = ir_q[SHAMT_LSB +: 5];
    funct          = ir_q[5:0];
    imm_sext       = sext16(ir_q[15:0]);
    target         = ir_q[25:0];
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one instance with 1-cycle and one with
// 3-cycle instruction memory, sharing control stimulus.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0, pc_update = 1'b0, branch = 1'b0, branch_taken = 1'b0;
  logic        jump = 1'b0, ret_pc = 1'b0, halt = 1'b0;
  logic [31:0] ret_addr = '0;

  logic [31:0] pc1, pp1, imm1, pc3, pp3, imm3;
  logic        val1, busy1, hlt1, val3, busy3, hlt3;
  logic [5:0]  opc1, fn1, opc3, fn3;
  logic [4:0]  rs1, rt1, rd1, sh1, rs3, rt3, rd3, sh3;
  logic [25:0] tg1, tg3;

  logic [31:0] mrd1 = '0;
  logic [31:0] mp0 = '0, mp1 = '0, mp2 = '0;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(32)) m1 ();
  instr_fetch_unit_if #(.ADDR_W(32)) m3 ();

  instr_fetch_unit #(.ADDR_W(32), .IMEM_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc_update(pc_update),
    .branch(branch), .branch_taken(branch_taken), .jump(jump), .ret_pc(ret_pc),
    .ret_addr(ret_addr), .halt(halt), .imem(m1), .pc(pc1), .pc_plus4(pp1),
    .instr_valid(val1), .busy(busy1), .halted(hlt1), .opcode(opc1), .rs(rs1),
    .rt(rt1), .rd(rd1), .shamt(sh1), .funct(fn1), .imm_sext(imm1), .target(tg1)
  );

  instr_fetch_unit #(.ADDR_W(32), .IMEM_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc_update(pc_update),
    .branch(branch), .branch_taken(branch_taken), .jump(jump), .ret_pc(ret_pc),
    .ret_addr(ret_addr), .halt(halt), .imem(m3), .pc(pc3), .pc_plus4(pp3),
    .instr_valid(val3), .busy(busy3), .halted(hlt3), .opcode(opc3), .rs(rs3),
    .rt(rt3), .rd(rd3), .shamt(sh3), .funct(fn3), .imm_sext(imm3), .target(tg3)
  );

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0022_1820;
      32'h0000_0010: return 32'h1000_FFFE;
      32'h4000_0000: return 32'h0800_0010;
      default:       return {6'h23, 5'd1, 5'd2, a[15:0]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (m1.imem_en) mrd1 <= imem_word(m1.imem_addr);
    if (m3.imem_en) mp0 <= imem_word(m3.imem_addr);
    mp1 <= mp0;
    mp2 <= mp1;
  end
  assign m1.imem_rdata = mrd1;
  assign m3.imem_rdata = mp2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] a);
    ret_pc = 1'b1; ret_addr = a; pc_update = 1'b1;
    tick();
    ret_pc = 1'b0; pc_update = 1'b0;
  endtask

  task automatic fetch1();
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_pc", pc1, 32'h0);
    chk("rst_valid", 32'(val1), 32'h0);
    chk("rst_busy", 32'(busy1), 32'h0);
    chk("rst_halted", 32'(hlt1), 32'h0);
    chk("rst_imem_en", 32'(m1.imem_en), 32'h0);
    chk("rst_ir", imm1, 32'h0);
    rst_n = 1'b1;
    tick();

    // Fetch at pc=0, 1-cycle memory
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("f1_issue_en", 32'(m1.imem_en), 32'h1);
    chk("f1_issue_addr", m1.imem_addr, 32'h0);
    chk("f1_issue_busy", 32'(busy1), 32'h1);
    tick();
    chk("f1_wait_en", 32'(m1.imem_en), 32'h0);
    chk("f1_wait_valid", 32'(val1), 32'h0);
    chk("f1_wait_busy", 32'(busy1), 32'h1);
    tick();
    chk("f1_valid", 32'(val1), 32'h1);
    chk("f1_busy", 32'(busy1), 32'h0);
    chk("f1_opcode", 32'(opc1), 32'h0);
    chk("f1_rs", 32'(rs1), 32'h1);
    chk("f1_rt", 32'(rt1), 32'h2);
    chk("f1_rd", 32'(rd1), 32'h3);
    chk("f1_shamt", 32'(sh1), 32'h0);
    chk("f1_funct", 32'(fn1), 32'h20);

    // Branch with negative offset, taken and not taken
    set_pc(32'h10);
    chk("br_setpc", pc1, 32'h10);
    chk("br_setpc_valid", 32'(val1), 32'h0);
    fetch1();
    chk("br_imm", imm1, 32'hFFFF_FFFE);
    branch = 1'b1; branch_taken = 1'b1; pc_update = 1'b1;
    tick();
    chk("br_taken_pc", pc1, 32'h0C);
    branch_taken = 1'b0; pc_update = 1'b0; branch = 1'b0;
    set_pc(32'h10);
    branch = 1'b1; branch_taken = 1'b0; pc_update = 1'b1;
    tick();
    branch = 1'b0; pc_update = 1'b0;
    chk("br_not_taken_pc", pc1, 32'h14);
    chk("pc_plus4", pp1, 32'h18);

    // Sequential wrap and jump
    set_pc(32'hFFFF_FFFC);
    pc_update = 1'b1;
    tick();
    pc_update = 1'b0;
    chk("seq_wrap_pc", pc1, 32'h0);
    set_pc(32'h4000_0000);
    fetch1();
    chk("jmp_target_field", 32'(tg1), 32'h10);
    jump = 1'b1; pc_update = 1'b1;
    tick();
    jump = 1'b0; pc_update = 1'b0;
    chk("jmp_pc", pc1, 32'h4000_0040);

    // Return beats jump; low address bits cleared
    ret_pc = 1'b1; jump = 1'b1; ret_addr = 32'h123; pc_update = 1'b1;
    tick();
    ret_pc = 1'b0; jump = 1'b0; pc_update = 1'b0;
    chk("ret_prio_pc", pc1, 32'h120);

    // 3-cycle memory: repeated request ignored, capture 4 clocks after request
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    fetch_req = 1'b1;
    tick();
    chk("l3_issue_en", 32'(m3.imem_en), 32'h1);
    chk("l3_issue_addr", m3.imem_addr, 32'h0);
    tick();
    chk("l3_wait_en", 32'(m3.imem_en), 32'h0);
    tick();
    fetch_req = 1'b0;
    chk("l3_req_ignored_en", 32'(m3.imem_en), 32'h0);
    chk("l3_wait_busy", 32'(busy3), 32'h1);
    tick();
    chk("l3_valid_early", 32'(val3), 32'h0);
    tick();
    chk("l3_valid", 32'(val3), 32'h1);
    chk("l3_opcode", 32'(opc3), 32'h0);
    chk("l3_rs", 32'(rs3), 32'h1);
    chk("l3_rt", 32'(rt3), 32'h2);
    chk("l3_rd", 32'(rd3), 32'h3);
    chk("l3_shamt", 32'(sh3), 32'h0);
    chk("l3_funct", 32'(fn3), 32'h20);
    chk("l3_pc_plus4", pp3, 32'h4);

    pc_update = 1'b1; fetch_req = 1'b1;
    tick();
    pc_update = 1'b0; fetch_req = 1'b0;
    chk("l3_upd_pc", pc3, 32'h4);
    chk("l3_upd_en", 32'(m3.imem_en), 32'h1);
    chk("l3_upd_addr", m3.imem_addr, 32'h4);
    chk("l3_upd_valid", 32'(val3), 32'h0);
    repeat (4) tick();
    chk("l3_new_valid", 32'(val3), 32'h1);
    chk("l3_new_imm", imm3, 32'h4);
    chk("l3_new_target", 32'(tg3), 32'h022_0004);

    // Halt during WAIT: IR untouched, PC frozen, requests ignored
    pc_update = 1'b1; fetch_req = 1'b1;
    tick();
    pc_update = 1'b0; fetch_req = 1'b0;
    tick();
    halt = 1'b1; pc_update = 1'b1; fetch_req = 1'b1;
    tick();
    chk("halt_halted", 32'(hlt3), 32'h1);
    chk("halt_busy", 32'(busy3), 32'h0);
    chk("halt_en", 32'(m3.imem_en), 32'h0);
    chk("halt_pc", pc3, 32'h8);
    halt = 1'b0;
    repeat (4) tick();
    pc_update = 1'b0; fetch_req = 1'b0;
    chk("halt_sticky", 32'(hlt3), 32'h1);
    chk("halt_pc_frozen", pc3, 32'h8);
    chk("halt_en_idle", 32'(m3.imem_en), 32'h0);
    chk("halt_ir_kept", imm3, 32'h4);

    // Reset pulse mid-fetch abandons the fetch
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_exit_halt", 32'(hlt3), 32'h0);
    set_pc(32'h20);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    chk("mid_busy", 32'(busy3), 32'h1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_pc", pc3, 32'h0);
    chk("mid_rst_valid", 32'(val3), 32'h0);
    chk("mid_rst_busy", 32'(busy3), 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("mid_late_valid", 32'(val3), 32'h0);
    chk("mid_late_ir", imm3, 32'h0);
    chk("mid_late_pc", pc3, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
